// File: rtl/xgmii_rx_deframer.sv
// XGMII receive deframer: finds Start in lane 0 or 4, checks/strips preamble+SFD,
// realigns lane-4 frames and emits a word stream with SOP/EOP/keep/error.
module xgmii_rx_deframer (
  input  logic        xgmii_clk,
  input  logic        sys_rst,
  input  logic [7:0]  xgmii_rxc,
  input  logic [63:0] xgmii_rxd,
  output logic        rx_valid,
  output logic [63:0] rx_data,
  output logic [7:0]  rx_keep,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic        rx_err,
  output logic [15:0] bad_pre_cnt
);

  localparam logic [7:0] CODE_START = 8'hFB;
  localparam logic [7:0] CODE_TERM  = 8'hFD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE4  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'h001 << n) - 9'h001;
    return m[7:0];
  endfunction

  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

  state_t      state_r;
  logic        align_r;
  logic [31:0] held_r;
  logic        sop_next_r;
  logic [7:0]  drain_keep_r;
  logic        pend_valid_r;
  logic [63:0] pend_data_r;
  logic [7:0]  pend_keep_r;
  logic        pend_sop_r;
  logic        pend_eop_r;
  logic        pend_err_r;

  logic [2:0]  ctrl_lane_s;
  logic        ctrl_found_s;
  logic [7:0]  ctrl_byte_s;
  logic [3:0]  term_n_s;
  logic        term_s;
  logic        err_s;
  logic        lane0_start_s;
  logic        lane0_ok_s;
  logic        lane4_start_s;
  logic        lane4_ok_s;
  logic        pre4_ok_s;
  logic [63:0] al_word_s;
  state_t      start_state_s;
  logic        start_bad_s;
  logic        bad_inc_s;
  logic        abort_s;
  logic        retag_s;

  // Decode the incoming word: first control lane, Start/preamble checks, realigned word.
  always_comb begin
    ctrl_lane_s = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      ctrl_lane_s = xgmii_rxc[i] ? 3'(i) : ctrl_lane_s;
    end
    ctrl_found_s  = |xgmii_rxc;
    ctrl_byte_s   = xgmii_rxd[8*ctrl_lane_s +: 8];
    term_n_s      = {1'b0, ctrl_lane_s};
    term_s        = ctrl_found_s && (ctrl_byte_s == CODE_TERM);
    err_s         = ctrl_found_s && !term_s;
    lane0_start_s = xgmii_rxc[0] && (xgmii_rxd[7:0] == CODE_START);
    lane0_ok_s    = (xgmii_rxc == 8'h01) && (xgmii_rxd == 64'hD555_5555_5555_55FB);
    lane4_start_s = xgmii_rxc[4] && (xgmii_rxd[39:32] == CODE_START);
    lane4_ok_s    = lane4_start_s && (xgmii_rxc[7:5] == 3'b000) && (xgmii_rxd[63:40] == 24'h55_5555);
    pre4_ok_s     = (xgmii_rxc[3:0] == 4'h0) && (xgmii_rxd[31:0] == 32'hD555_5555);
    al_word_s     = {xgmii_rxd[31:0], held_r};

    if (lane0_start_s) begin
      start_state_s = lane0_ok_s ? ST_DATA : ST_IDLE;
      start_bad_s   = !lane0_ok_s;
    end else if (lane4_start_s) begin
      start_state_s = lane4_ok_s ? ST_PRE4 : ST_IDLE;
      start_bad_s   = !lane4_ok_s;
    end else begin
      start_state_s = ST_IDLE;
      start_bad_s   = 1'b0;
    end

    case (state_r)
      ST_IDLE, ST_DRAIN: bad_inc_s = start_bad_s;
      ST_PRE4:           bad_inc_s = !pre4_ok_s;
      ST_DATA:           bad_inc_s = err_s && start_bad_s;
      default:           bad_inc_s = 1'b0;
    endcase

    // The pending word may belong to the previous frame (DRAIN -> DATA); never retag that one.
    abort_s = (state_r == ST_DATA) && err_s && pend_valid_r && !pend_eop_r;
    retag_s = abort_s || ((state_r == ST_DATA) && !align_r && term_s &&
                          (ctrl_lane_s == 3'd0) && pend_valid_r && !pend_eop_r);
  end

  // Frame FSM, pending-word register and output register.
  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      state_r      <= ST_IDLE;
      align_r      <= 1'b0;
      held_r       <= 32'h0;
      sop_next_r   <= 1'b0;
      drain_keep_r <= 8'h00;
      pend_valid_r <= 1'b0;
      pend_data_r  <= 64'h0;
      pend_keep_r  <= 8'h00;
      pend_sop_r   <= 1'b0;
      pend_eop_r   <= 1'b0;
      pend_err_r   <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= 64'h0;
      rx_keep      <= 8'h00;
      rx_sop       <= 1'b0;
      rx_eop       <= 1'b0;
      rx_err       <= 1'b0;
      bad_pre_cnt  <= 16'h0000;
    end else begin
      rx_valid <= pend_valid_r;
      rx_data  <= pend_data_r;
      rx_keep  <= pend_keep_r;
      rx_sop   <= pend_sop_r;
      rx_eop   <= pend_eop_r | retag_s;
      rx_err   <= pend_err_r | abort_s;
      if (bad_inc_s && (bad_pre_cnt != 16'hFFFF)) begin
        bad_pre_cnt <= bad_pre_cnt + 16'h0001;
      end

      pend_valid_r <= 1'b0;
      pend_data_r  <= 64'h0;
      pend_keep_r  <= 8'h00;
      pend_sop_r   <= 1'b0;
      pend_eop_r   <= 1'b0;
      pend_err_r   <= 1'b0;

      case (state_r)
        ST_IDLE, ST_DRAIN: begin
          if (state_r == ST_DRAIN) begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= mask_bytes({32'h0, held_r}, drain_keep_r);
            pend_keep_r  <= drain_keep_r;
            pend_eop_r   <= 1'b1;
          end
          state_r    <= start_state_s;
          align_r    <= 1'b0;
          sop_next_r <= 1'b1;
        end
        ST_PRE4: begin
          if (pre4_ok_s) begin
            held_r  <= xgmii_rxd[63:32];
            align_r <= 1'b1;
            state_r <= ST_DATA;
          end else begin
            state_r    <= start_state_s;
            align_r    <= 1'b0;
            sop_next_r <= 1'b1;
          end
        end
        ST_DATA: begin
          if (term_s) begin
            sop_next_r <= 1'b0;
            if (!align_r) begin
              state_r <= ST_IDLE;
              if (ctrl_lane_s != 3'd0) begin
                pend_valid_r <= 1'b1;
                pend_data_r  <= mask_bytes(xgmii_rxd, keep_mask(term_n_s));
                pend_keep_r  <= keep_mask(term_n_s);
                pend_sop_r   <= sop_next_r;
                pend_eop_r   <= 1'b1;
              end
            end else if (ctrl_lane_s <= 3'd4) begin
              state_r      <= ST_IDLE;
              pend_valid_r <= 1'b1;
              pend_data_r  <= mask_bytes(al_word_s, keep_mask(term_n_s + 4'd4));
              pend_keep_r  <= keep_mask(term_n_s + 4'd4);
              pend_sop_r   <= sop_next_r;
              pend_eop_r   <= 1'b1;
            end else begin
              // Lanes 4..t-1 do not fit: emit a full word now and the tail from DRAIN.
              state_r      <= ST_DRAIN;
              pend_valid_r <= 1'b1;
              pend_data_r  <= al_word_s;
              pend_keep_r  <= 8'hFF;
              pend_sop_r   <= sop_next_r;
              held_r       <= xgmii_rxd[63:32];
              drain_keep_r <= keep_mask(term_n_s - 4'd4);
            end
          end else if (err_s) begin
            state_r    <= start_state_s;
            align_r    <= 1'b0;
            sop_next_r <= 1'b1;
          end else begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= align_r ? al_word_s : xgmii_rxd;
            pend_keep_r  <= 8'hFF;
            pend_sop_r   <= sop_next_r;
            sop_next_r   <= 1'b0;
            if (align_r) begin
              held_r <= xgmii_rxd[63:32];
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// Directed, table-driven bench for xgmii_rx_deframer plus a hand-written reset sequence.
module tb_xgmii_rx_deframer;

  logic        xgmii_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  xgmii_rxc;
  logic [63:0] xgmii_rxd;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic [7:0]  rx_keep;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_err;
  logic [15:0] bad_pre_cnt;

  always #5 xgmii_clk = ~xgmii_clk;

  xgmii_rx_deframer dut (
    .xgmii_clk   (xgmii_clk),
    .sys_rst     (sys_rst),
    .xgmii_rxc   (xgmii_rxc),
    .xgmii_rxd   (xgmii_rxd),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_keep     (rx_keep),
    .rx_sop      (rx_sop),
    .rx_eop      (rx_eop),
    .rx_err      (rx_err),
    .bad_pre_cnt (bad_pre_cnt)
  );

  localparam logic [7:0]  IDLE_C = 8'hFF;
  localparam logic [63:0] IDLE_D = 64'h0707_0707_0707_0707;
  localparam logic [7:0]  S0_C   = 8'h01;
  localparam logic [63:0] S0_D   = 64'hD555_5555_5555_55FB;
  localparam logic [7:0]  S4_C   = 8'h1F;
  localparam logic [63:0] S4_D   = 64'h5555_55FB_0707_0707;
  localparam logic [7:0]  T0_C   = 8'hFF;
  localparam logic [63:0] T0_D   = 64'h0707_0707_0707_07FD;

  typedef struct {
    logic [7:0]  rxc;
    logic [63:0] rxd;
    logic        ev;
    logic [63:0] ed;
    logic [7:0]  ek;
    logic        es;
    logic        ee;
    logic        er;
    logic [15:0] ec;
  } vec_t;

  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] cnt_e  = 16'h0000;

  // Eight consecutive payload bytes b, b+1, ... with b in lane 0.
  function automatic logic [63:0] wb(input logic [7:0] b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = b + 8'(i);
    return r;
  endfunction

  function automatic logic [63:0] kexp(input logic [7:0] k);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = k[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  task automatic ov(input logic [7:0] c, input logic [63:0] d, input logic [63:0] ed,
                    input logic [7:0] ek, input logic es, input logic ee, input logic er);
    vec_t v;
    v.rxc = c; v.rxd = d; v.ev = 1'b1; v.ed = ed; v.ek = ek;
    v.es = es; v.ee = ee; v.er = er; v.ec = cnt_e;
    vecs.push_back(v);
  endtask

  task automatic nv(input logic [7:0] c, input logic [63:0] d);
    vec_t v;
    v.rxc = c; v.rxd = d; v.ev = 1'b0; v.ed = 64'h0; v.ek = 8'h00;
    v.es = 1'b0; v.ee = 1'b0; v.er = 1'b0; v.ec = cnt_e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [7:0] c, input logic [63:0] d);
    xgmii_rxc = c;
    xgmii_rxd = d;
    @(posedge xgmii_clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic ev, input logic [63:0] ed,
                           input logic [7:0] ek, input logic es, input logic ee,
                           input logic er, input logic [15:0] ec);
    logic ok;
    ok = (rx_valid == ev) && (bad_pre_cnt == ec);
    if (ev) begin
      ok = ok && ((rx_data & kexp(ek)) == (ed & kexp(ek))) && (rx_keep == ek) &&
           (rx_sop == es) && (rx_eop == ee) && (rx_err == er);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h k=%h sop=%b eop=%b err=%b cnt=%0d, want v=%b d=%h k=%h sop=%b eop=%b err=%b cnt=%0d",
               name, rx_valid, rx_data, rx_keep, rx_sop, rx_eop, rx_err, bad_pre_cnt,
               ev, ed, ek, es, ee, er, ec);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({rx_valid, rx_data, rx_keep, rx_sop, rx_eop, rx_err, bad_pre_cnt} != 91'h0) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h k=%h sop=%b eop=%b err=%b cnt=%0d, want all zero",
               name, rx_valid, rx_data, rx_keep, rx_sop, rx_eop, rx_err, bad_pre_cnt);
    end
  endtask

  initial begin
    logic seen;
    int   at;

    sys_rst = 1'b1;
    drive(IDLE_C, IDLE_D);
    drive(IDLE_C, IDLE_D);
    check_zero("reset_state");
    sys_rst = 1'b0;

    // Lane-0 Start, 64-byte payload 00..3F, Terminate in lane 0.
    nv(IDLE_C, IDLE_D);
    nv(S0_C, S0_D);
    nv(8'h00, wb(8'h00));
    for (int k = 1; k < 8; k++) ov(8'h00, wb(8'(8*k)), wb(8'(8*(k-1))), 8'hFF, k == 1, 1'b0, 1'b0);
    ov(T0_C, T0_D, wb(8'h38), 8'hFF, 1'b0, 1'b1, 1'b0);
    nv(IDLE_C, IDLE_D);

    // Lane-4 Start, 65-byte payload, Terminate in lane 5 -> DRAIN word keep 01.
    nv(S4_C, S4_D);
    nv(8'h00, 64'h0302_0100_D555_5555);
    nv(8'h00, wb(8'h04));
    for (int k = 1; k < 7; k++) ov(8'h00, wb(8'(4+8*k)), wb(8'(8*(k-1))), 8'hFF, k == 1, 1'b0, 1'b0);
    ov(8'hE0, 64'h0707_FD40_3F3E_3D3C, wb(8'h30), 8'hFF, 1'b0, 1'b0, 1'b0);
    ov(IDLE_C, IDLE_D, wb(8'h38), 8'hFF, 1'b0, 1'b0, 1'b0);
    ov(IDLE_C, IDLE_D, 64'h40, 8'h01, 1'b0, 1'b1, 1'b0);
    nv(IDLE_C, IDLE_D);

    // Lane-4 frame ending in lane 6, back-to-back with a lane-4 frame ending in lane 7.
    nv(S4_C, S4_D);
    nv(8'h00, 64'h0302_0100_D555_5555);
    nv(8'hC0, 64'h07FD_0908_0706_0504);
    ov(S4_C, S4_D, wb(8'h00), 8'hFF, 1'b1, 1'b0, 1'b0);
    ov(8'h00, 64'hA3A2_A1A0_D555_5555, 64'h0908, 8'h03, 1'b0, 1'b1, 1'b0);
    nv(8'h80, 64'hFDAA_A9A8_A7A6_A5A4);
    ov(IDLE_C, IDLE_D, wb(8'hA0), 8'hFF, 1'b1, 1'b0, 1'b0);
    ov(IDLE_C, IDLE_D, 64'hAA_A9A8, 8'h07, 1'b0, 1'b1, 1'b0);
    nv(IDLE_C, IDLE_D);

    // Error code in lane 2 mid-frame aborts the frame on the pending word.
    nv(S0_C, S0_D);
    nv(8'h00, wb(8'h00));
    ov(8'h00, wb(8'h08), wb(8'h00), 8'hFF, 1'b1, 1'b0, 1'b0);
    ov(8'h04, 64'h1716_1514_13FE_1110, wb(8'h08), 8'hFF, 1'b0, 1'b1, 1'b1);
    nv(IDLE_C, IDLE_D);
    nv(IDLE_C, IDLE_D);

    // Corrupted SFD drops the frame and counts; the next short frame passes.
    cnt_e = 16'h0001;
    nv(8'h01, 64'hD455_5555_5555_55FB);
    nv(8'h00, wb(8'h00));
    nv(8'h00, wb(8'h08));
    nv(T0_C, T0_D);
    nv(IDLE_C, IDLE_D);
    nv(S0_C, S0_D);
    nv(8'hF8, 64'h0707_0707_FD82_8180);
    ov(IDLE_C, IDLE_D, 64'h82_8180, 8'h07, 1'b1, 1'b1, 1'b0);
    nv(IDLE_C, IDLE_D);

    foreach (vecs[i]) begin
      drive(vecs[i].rxc, vecs[i].rxd);
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ek,
                vecs[i].es, vecs[i].ee, vecs[i].er, vecs[i].ec);
    end

    // Reset pulse mid-frame: outputs clear, no EOP, next frame received normally.
    drive(S0_C, S0_D);
    drive(8'h00, wb(8'h00));
    drive(8'h00, wb(8'h08));
    sys_rst = 1'b1;
    drive(8'h00, wb(8'h10));
    check_zero("rst_mid_frame");
    sys_rst = 1'b0;
    seen = 1'b0;
    drive(8'h00, wb(8'h18));
    seen = seen | rx_valid | rx_eop;
    drive(T0_C, T0_D);
    seen = seen | rx_valid | rx_eop;
    drive(IDLE_C, IDLE_D);
    seen = seen | rx_valid | rx_eop;
    drive(IDLE_C, IDLE_D);
    seen = seen | rx_valid | rx_eop;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_no_output: got output after reset = %b, want 0", seen);
    end

    drive(S0_C, S0_D);
    drive(8'h00, wb(8'h40));
    at = -1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(T0_C, T0_D);
      else        drive(IDLE_C, IDLE_D);
      if (rx_valid) begin
        at = i;
        break;
      end
    end
    checks++;
    if (at != 0) begin
      errors++;
      $display("FAIL post_rst_latency: got word at step %0d, want step 0", at);
    end
    if (at >= 0) begin
      check_out("post_rst_frame", 1'b1, wb(8'h40), 8'hFF, 1'b1, 1'b1, 1'b0, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
